imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-002 SHALL have port clear_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, single-cycle request to begin a load.
REQ-004 SHALL have port word_count, input, 5, number of 32-bit words to load (0..16), sampled at start.
REQ-005 SHALL have port rx_valid, input, 1, rx_data byte is valid.
REQ-006 SHALL have port rx_data, input, 8, serial program byte stream, MSB-first within each word.
REQ-007 SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1, instruction-memory write strobe.
REQ-009 SHALL have port mem_addr, output, 32, byte address of the write (word aligned).
REQ-010 SHALL have port mem_wdata, output, 32, assembled instruction word.
REQ-011 SHALL have port cpu_hold, output, 1, holds the pipeline in clear while high.
REQ-012 SHALL have port busy, output, 1, load in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of load.
REQ-014 SHALL have port load_err, output, 1, checksum mismatch flag, sticky until next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CSUM, DONE; all outputs are registered.
REQ-016 In IDLE, rx_ready SHALL be 0 and start SHALL move to LOAD (word_count>0) or CSUM (word_count=0), clear byte count, word count, address (0) and checksum, and clear load_err.
REQ-017 In LOAD and CSUM, rx_ready SHALL be 1; a byte is accepted only when rx_valid and rx_ready are both 1.
REQ-018 In LOAD, accepted bytes SHALL shift into the word MSB-first; the running checksum is the XOR of all accepted data bytes.
REQ-019 On the 4th accepted byte of a word, the next cycle SHALL have mem_we=1 for exactly one cycle, with mem_wdata=the word and mem_addr=4*word index; mem_addr then advances by 4.
REQ-020 After the write of word word_count-1, the FSM SHALL enter CSUM in the same cycle as that write; bytes may be accepted back-to-back across word boundaries with no bubble.
REQ-021 In CSUM, the next accepted byte SHALL be compared with the running checksum; the FSM goes to DONE and sets load_err=1 on mismatch.
REQ-022 In DONE, done SHALL be 1 for one cycle, then the FSM returns to IDLE.
REQ-023 cpu_hold SHALL rise on accepted start and fall in the DONE cycle only if load_err=0; after an error it stays 1 until a later successful load.
REQ-024 busy SHALL be 1 in LOAD and CSUM, and 0 otherwise.
REQ-025 start outside IDLE SHALL be ignored; rx_valid while rx_ready=0 SHALL be ignored (no byte consumed).
REQ-026 Address arithmetic SHALL be 32-bit unsigned; word index never exceeds 15, and word_count>16 is clamped to 16.

Reset
REQ-027 On clear_n=0, the module SHALL asynchronously force IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, load_err=0, cpu_hold=1, and all counters and the checksum to 0.
REQ-028 Reset mid-load SHALL abandon the partial word with no write, and the release of clear_n SHALL be followed by IDLE with cpu_hold=1.

Structure
REQ-029 The state enum, IMEM_WORDS=16 and BYTES_PER_WORD=4 SHALL live in a shared package used by the pipeline top.
REQ-030 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-031 The bench SHALL apply reset mid-operation, then release it -> IDLE, cpu_hold=1, mem_we=0, and all other outputs 0.
REQ-032 The bench SHALL issue start with word_count=2 and bytes 8C 01 00 04 8C 02 00 08 0F -> writes 8C010004@0x0 and 8C020008@0x4, then done pulse, load_err=0 and cpu_hold=0.
REQ-033 The bench SHALL repeat REQ-032 with checksum byte 0E -> both words written, load_err=1, cpu_hold stays 1.
REQ-034 The bench SHALL drive rx_valid with 1-cycle gaps between every byte -> results identical to REQ-032, with no extra or missing mem_we.
REQ-035 The bench SHALL assert clear_n=0 after 6 bytes of a 2-word load -> exactly one write (0x0), no second write, IDLE and cpu_hold=1.
REQ-036 The bench SHALL issue start with word_count=0 and checksum byte 00 -> no mem_we, done pulse, load_err=0; a second start during busy is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and sizing for the instruction-memory loader.
//   state_t          - loader FSM states
//   IMEM_WORDS       - maximum number of words a single load may write
//   BYTES_PER_WORD   - serial bytes assembled into one instruction word
//   last_word_idx()  - clamped index of the final word of a load
package imem_loader_pkg;

    localparam int unsigned IMEM_WORDS     = 16;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned BCNT_W         = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index of the last word to write; counts above IMEM_WORDS clamp to the full memory.
    // Only meaningful for a non-zero count.
    function automatic logic [IDX_W-1:0] last_word_idx(input logic [CNT_W-1:0] wc);
        logic [CNT_W-1:0] w_clamped;
        w_clamped = (wc > CNT_W'(IMEM_WORDS)) ? CNT_W'(IMEM_WORDS) : wc;
        return IDX_W'(w_clamped - CNT_W'(1));
    endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream into instruction memory as 32-bit words,
// then checks a trailing XOR checksum byte while holding the CPU in clear.
// Ports:
//   clk, clear_n          - clock, asynchronous active-low reset
//   start, word_count     - load request and number of words (sampled at start)
//   rx_valid, rx_data     - incoming program bytes, MSB-first per word
//   rx_ready              - byte accepted when rx_valid & rx_ready
//   mem_we/addr/wdata     - one-cycle instruction-memory write
//   cpu_hold              - pipeline clear hold, released only by a clean load
//   busy, done, load_err  - status: loading, end pulse, sticky checksum error
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                clear_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    word_count,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_data,
    output logic                rx_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                load_err
);

    state_t                 r_state;
    logic [BCNT_W-1:0]      r_byte_cnt;
    logic [IDX_W-1:0]       r_word_idx;
    logic [IDX_W-1:0]       r_last_idx;
    logic [WORD_W-BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0]      r_csum;

    logic                   w_accept;
    logic                   w_word_end;
    logic                   w_last_word;
    logic                   w_csum_bad;
    logic [WORD_W-1:0]      w_word;

    // Handshake and word-assembly helpers
    assign w_accept    = rx_valid & rx_ready;
    assign w_word_end  = (r_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign w_last_word = (r_word_idx == r_last_idx);
    assign w_csum_bad  = (rx_data != r_csum);
    assign w_word      = {r_shift, rx_data};

    // Loader FSM with registered outputs
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_shift    <= '0;
            r_csum     <= '0;
            rx_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;

            // Address moves to the next word once the current write has been presented
            if (mem_we) begin
                mem_addr <= mem_addr + ADDR_W'(BYTES_PER_WORD);
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_byte_cnt <= '0;
                        r_word_idx <= '0;
                        r_shift    <= '0;
                        r_csum     <= '0;
                        mem_addr   <= '0;
                        load_err   <= 1'b0;
                        cpu_hold   <= 1'b1;
                        rx_ready   <= 1'b1;
                        busy       <= 1'b1;
                        if (word_count != '0) begin
                            r_last_idx <= last_word_idx(word_count);
                            r_state    <= LOAD;
                        end else begin
                            r_state    <= CSUM;
                        end
                    end
                end

                LOAD: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ rx_data;
                        r_shift    <= {r_shift[WORD_W-2*BYTE_W-1:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                        if (w_word_end) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= w_word;
                            // Final word: move to CSUM so it overlaps the write cycle
                            if (w_last_word) begin
                                r_state <= CSUM;
                            end else begin
                                r_word_idx <= r_word_idx + IDX_W'(1);
                            end
                        end
                    end
                end

                CSUM: begin
                    if (w_accept) begin
                        load_err <= w_csum_bad;
                        cpu_hold <= w_csum_bad;
                        done     <= 1'b1;
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        r_state  <= DONE;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven directed bench for imem_loader plus
// hand-written reset and idle-handshake sequences.
module tb_imem_loader;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic [4:0]  word_count;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        load_err;

    imem_loader dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .word_count (word_count),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 6;
    localparam int MAXB = 65;

    typedef struct {
        logic [4:0] wc;
        int         n_bytes;
        int         gap;
        bit         dup_start;
        int         exp_writes;
        logic       exp_err;
        logic       exp_hold;
    } vec_t;

    vec_t        tbl [NV];
    string       tbl_name [NV];
    logic [7:0]  tbl_bytes [NV][MAXB];

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    // Record every write and done pulse seen on the falling edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [4:0] wc);
        @(negedge clk);
        start = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present bytes [0..count-1] of row r; each waits (bounded) for rx_ready
    task automatic drive_bytes(input int r, input int count, input int gap, output int n_acc);
        int cyc;
        n_acc = 0;
        for (int i = 0; i < count; i++) begin
            rx_data  = tbl_bytes[r][i];
            rx_valid = 1'b1;
            cyc = 0;
            while (rx_ready !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 20) break;
            @(negedge clk);
            n_acc++;
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_row(input int r);
        int n_acc;
        logic [31:0] exp_w;
        clear_log();
        pulse_start(tbl[r].wc);
        if (tbl[r].dup_start) begin
            // Second start while busy must not restart the load
            start = 1'b1;
            word_count = 5'd2;
            @(negedge clk);
            start = 1'b0;
            chk({tbl_name[r], "_busy"}, 32'(busy), 32'd1);
        end
        drive_bytes(r, tbl[r].n_bytes, tbl[r].gap, n_acc);
        repeat (3) @(negedge clk);
        chk({tbl_name[r], "_accepted"}, 32'(n_acc), 32'(tbl[r].n_bytes));
        chk({tbl_name[r], "_nwrites"}, 32'(wr_addr.size()), 32'(tbl[r].exp_writes));
        for (int k = 0; k < wr_addr.size() && k < tbl[r].exp_writes; k++) begin
            exp_w = {tbl_bytes[r][4*k], tbl_bytes[r][4*k+1], tbl_bytes[r][4*k+2], tbl_bytes[r][4*k+3]};
            chk($sformatf("%s_addr%0d", tbl_name[r], k), wr_addr[k], 32'(4*k));
            chk($sformatf("%s_data%0d", tbl_name[r], k), wr_data[k], exp_w);
        end
        chk({tbl_name[r], "_done"}, 32'(done_cnt), 32'd1);
        chk({tbl_name[r], "_err"}, 32'(load_err), 32'(tbl[r].exp_err));
        chk({tbl_name[r], "_hold"}, 32'(cpu_hold), 32'(tbl[r].exp_hold));
        chk({tbl_name[r], "_idle"}, {30'd0, busy, rx_ready}, 32'd0);
    endtask

    initial begin
        logic [7:0] prog [9];
        logic [7:0] one [5];
        int n_acc;

        clear_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        rx_valid = 1'b0;
        rx_data = '0;

        // Vector table
        prog = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h8C, 8'h02, 8'h00, 8'h08, 8'h0F};
        one  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        for (int r = 0; r < NV; r++)
            for (int i = 0; i < MAXB; i++) tbl_bytes[r][i] = 8'h00;
        for (int i = 0; i < 9; i++) begin
            tbl_bytes[0][i] = prog[i];
            tbl_bytes[1][i] = prog[i];
            tbl_bytes[2][i] = prog[i];
        end
        tbl_bytes[1][8] = 8'h0E;
        for (int i = 0; i < 5; i++) tbl_bytes[4][i] = one[i];
        for (int i = 0; i < 64; i++) tbl_bytes[5][i] = 8'(i);
        tbl_bytes[5][64] = 8'h00;   // XOR of 0..63 is zero

        tbl_name[0] = "two_ok";   tbl[0] = '{5'd2,  9,  0, 1'b0, 2,  1'b0, 1'b0};
        tbl_name[1] = "two_bad";  tbl[1] = '{5'd2,  9,  0, 1'b0, 2,  1'b1, 1'b1};
        tbl_name[2] = "two_gaps"; tbl[2] = '{5'd2,  9,  1, 1'b0, 2,  1'b0, 1'b0};
        tbl_name[3] = "zero";     tbl[3] = '{5'd0,  1,  0, 1'b1, 0,  1'b0, 1'b0};
        tbl_name[4] = "one_word"; tbl[4] = '{5'd1,  5,  0, 1'b0, 1,  1'b0, 1'b0};
        tbl_name[5] = "clamp17";  tbl[5] = '{5'd17, 65, 0, 1'b0, 16, 1'b0, 1'b0};

        // Power-on reset values
        repeat (2) @(negedge clk);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_flags", {27'd0, rx_ready, mem_we, busy, done, load_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        clear_n = 1'b1;
        @(negedge clk);

        // rx_valid in IDLE is ignored
        clear_log();
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        repeat (3) @(negedge clk);
        chk("idle_rdy", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_nowr", 32'(wr_addr.size()), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd1);

        for (int r = 0; r < NV; r++) run_row(r);

        // Reset after 6 bytes of a 2-word load: first word written, partial second abandoned
        clear_log();
        pulse_start(5'd2);
        drive_bytes(0, 6, 0, n_acc);
        chk("mid_accepted", 32'(n_acc), 32'd6);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_flags", {27'd0, rx_ready, mem_we, busy, done, load_err}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            chk("mid_addr0", wr_addr[0], 32'h0000_0000);
            chk("mid_data0", wr_data[0], 32'h8C01_0004);
        end
        chk("mid_done", 32'(done_cnt), 32'd0);
        chk("mid_hold", 32'(cpu_hold), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);

        // Clean load after the abandoned one releases the hold
        run_row(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
